// File: rtl/sprite_pkg.sv
`default_nettype none
// ============================================================================
// sprite_pkg : shared constants, pipeline-entry type and address helper for
//              the sprite fetch arbiter.                        rev 1.0
// ============================================================================
package sprite_pkg;

  localparam int NUM_REQ      = 4;
  localparam int SPRITE_W     = 20;
  localparam int SPRITE_H     = 30;
  localparam int SPRITE_DEPTH = SPRITE_W * SPRITE_H;
  localparam int PIX_W        = 5;
  localparam int ADDR_W       = 19;
  localparam int COORD_W      = 5;
  localparam int ID_W         = 2;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
    logic            oob;
  } pipe_entry_t;

  // Row-major linear address, widened to ADDR_W before the multiply.
  function automatic logic [ADDR_W-1:0] pix_addr(
    input logic [COORD_W-1:0] x,
    input logic [COORD_W-1:0] y,
    input int                 width
  );
    return ADDR_W'(y) * ADDR_W'(width) + ADDR_W'(x);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter : round-robin one-hot grant with last-grant pointer; the search
//              starts one past the most recent winner.          rev 1.0
// ============================================================================
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_valid
);

  logic [ID_W-1:0]    r_last;
  logic [NUM_REQ-1:0] w_gnt;
  logic [ID_W-1:0]    w_id;
  logic               w_found;
  logic [ID_W-1:0]    w_idx;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_last <= ID_W'(NUM_REQ - 1);
    end else if (w_found) begin
      r_last <= w_id;
    end
  end

  always_comb begin
    w_gnt   = '0;
    w_id    = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = ID_W'((int'(r_last) + k) % NUM_REQ);
      if (!w_found && req[w_idx]) begin
        w_found       = 1'b1;
        w_id          = w_idx;
        w_gnt[w_idx]  = 1'b1;
      end
    end
  end

  // Grant is suppressed during reset so nothing is accepted in that cycle.
  assign gnt       = Reset ? '0 : w_gnt;
  assign gnt_id    = w_id;
  assign gnt_valid = w_found & ~Reset;

endmodule
`default_nettype wire

// File: rtl/sprite_fetch_arbiter.sv
`default_nettype none
// ============================================================================
// sprite_fetch_arbiter : shares one sprite ROM read port among requesters with
//                        a fixed two-cycle request-to-response latency. rev 1.0
// ============================================================================
module sprite_fetch_arbiter
  import sprite_pkg::pipe_entry_t;
  import sprite_pkg::pix_addr;
  import sprite_pkg::PIX_W;
  import sprite_pkg::ADDR_W;
  import sprite_pkg::COORD_W;
  import sprite_pkg::ID_W;
#(
  parameter int NUM_REQ  = sprite_pkg::NUM_REQ,
  parameter int SPRITE_W = sprite_pkg::SPRITE_W,
  parameter int SPRITE_H = sprite_pkg::SPRITE_H
) (
  input  logic                            Clk,
  input  logic                            Reset,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ-1:0][COORD_W-1:0] req_x,
  input  logic [NUM_REQ-1:0][COORD_W-1:0] req_y,
  output logic [NUM_REQ-1:0]              gnt,
  output logic [ADDR_W-1:0]               rom_addr,
  input  logic [PIX_W-1:0]                rom_data,
  output logic                            rsp_valid,
  output logic [ID_W-1:0]                 rsp_id,
  output logic [PIX_W-1:0]                rsp_data,
  output logic                            rsp_oob
);

  logic [ID_W-1:0]    w_acc_id;
  logic               w_acc;
  logic [COORD_W-1:0] w_x;
  logic [COORD_W-1:0] w_y;
  logic               w_oob;
  logic [ADDR_W-1:0]  w_addr;
  logic               w_live;

  logic [ADDR_W-1:0]  r_addr;
  pipe_entry_t        r_s1;
  pipe_entry_t        r_s2;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .Clk       (Clk),
    .Reset     (Reset),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (w_acc_id),
    .gnt_valid (w_acc)
  );

  always_comb begin
    w_x    = req_x[w_acc_id];
    w_y    = req_y[w_acc_id];
    w_oob  = (int'(w_x) >= SPRITE_W) || (int'(w_y) >= SPRITE_H);
    w_addr = w_oob ? '0 : pix_addr(w_x, w_y, SPRITE_W);
  end

  // Stage 1 pairs with the address in flight to the ROM, stage 2 with rom_data.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_addr <= '0;
      r_s1   <= '0;
      r_s2   <= '0;
    end else begin
      if (w_acc) begin
        r_addr <= w_addr;
      end
      r_s1.valid <= w_acc;
      r_s1.id    <= w_acc_id;
      r_s1.oob   <= w_oob;
      r_s2       <= r_s1;
    end
  end

  // Outputs are gated by Reset so a response due in the reset cycle is dropped.
  always_comb begin
    w_live    = r_s2.valid & ~Reset;
    rom_addr  = Reset ? '0 : r_addr;
    rsp_valid = w_live;
    rsp_id    = w_live ? r_s2.id : '0;
    rsp_oob   = w_live & r_s2.oob;
    rsp_data  = (w_live && !r_s2.oob) ? rom_data : '0;
  end

endmodule
`default_nettype wire
